// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// PARITY_CHECK_EN (see serial_word_receiver) enables the PAR state.
package serial_rx_pkg;

  // Receiver frame states; PAR is only reachable when parity checking is built in
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_e;

  // Shift direction encodings as seen on DIR
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage : serial_rx_pkg

// File: rtl/serial_rx_shifter.sv
// Direction-selectable shift register plus bit counter for one data frame.
// Direction is latched on the start bit so later DIR changes do not disturb the frame.
module serial_rx_shifter
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_word_c,
  output logic             o_last_bit_c
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] w_sr_next;

  // Next shift-register value for the bit currently on i_sin
  always_comb begin
    w_sr_next = r_sr;
    if (r_dir == DIR_LSB_FIRST) begin
      w_sr_next = {i_sin, r_sr[WIDTH-1:1]};
    end else begin
      w_sr_next = {r_sr[WIDTH-2:0], i_sin};
    end
  end

  // Word as it stands after this edge: includes the sampled bit when shifting
  assign o_word_c     = i_shift ? w_sr_next : r_sr;
  assign o_last_bit_c = (r_cnt == LAST_CNT);

  // Shift register, bit counter and latched direction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_dir <= DIR_MSB_FIRST;
    end else if (i_start) begin
      r_cnt <= '0;
      r_dir <= i_dir;
    end else if (i_shift) begin
      r_sr <= w_sr_next;
      if (o_last_bit_c) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule : serial_rx_shifter

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: start bit, WIDTH data bits (MSB- or LSB-first),
// then a one-cycle DONE strobe with the word on a tri-stateable bus.
// Build option: define PARITY_CHECK_EN to append an even-parity bit to each frame
// and report mismatches on PERR; otherwise PERR is tied low.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIN,
  input  logic             SVALID,
  input  logic             DIR,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic             DONE,
  output logic             BUSY,
  output logic             PERR
);

  rx_state_e        r_state;
  rx_state_e        w_next_state;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_word;
  logic             w_last_bit;
  logic             w_start;
  logic             w_shift;
  logic             w_load;
  logic             w_done_set;
`ifdef PARITY_CHECK_EN
  logic             r_perr;
  logic             w_perr_d;
  logic             w_par_ok;
`endif

  serial_rx_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_start     (w_start),
    .i_dir       (DIR),
    .i_shift     (w_shift),
    .i_sin       (SIN),
    .o_word_c    (w_word),
    .o_last_bit_c(w_last_bit)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; edges without SVALID always hold the state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (SVALID && SIN) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (SVALID && w_last_bit) begin
`ifdef PARITY_CHECK_EN
          w_next_state = PAR;
`else
          w_next_state = IDLE;
`endif
        end
      end
      PAR: begin
        if (SVALID) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM output decode: shifter control, holding-register load and DONE request
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_load     = 1'b0;
    w_done_set = 1'b0;
`ifdef PARITY_CHECK_EN
    w_par_ok   = 1'b0;
    w_perr_d   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_start = SVALID && SIN;
      end
      DATA: begin
        w_shift = SVALID;
`ifndef PARITY_CHECK_EN
        w_load     = SVALID && w_last_bit;
        w_done_set = SVALID && w_last_bit;
`endif
      end
      PAR: begin
`ifdef PARITY_CHECK_EN
        w_par_ok   = ((^w_word) ^ SIN) == 1'b0;
        w_load     = SVALID && w_par_ok;
        w_done_set = SVALID;
        w_perr_d   = !w_par_ok;
`endif
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Registered status outputs and holding register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold <= '0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      DONE <= w_done_set;
      BUSY <= (w_next_state != IDLE);
      if (w_load) begin
        r_hold <= w_word;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error flag, refreshed on every completed frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_perr <= 1'b0;
    end else if (w_done_set) begin
      r_perr <= w_perr_d;
    end
  end

  assign PERR = r_perr;
`else
  assign PERR = 1'b0;
`endif

  // Tri-state parallel bus driver; OE never affects reception
  assign Q = OE ? r_hold : {WIDTH{1'bz}};

endmodule : serial_word_receiver
